// File: rtl/dm_responder.sv
// Memory-side responder for M-stage loads/stores: one request in flight, programmable
// response latency, word RAM with byte-enable writes and a one-cycle trace per store.
module dm_responder #(
    parameter int          DEPTH   = 3072,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [1:0]  dbg_state
);
    // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
    // ready never depends on valid, and a response stays stable until it is taken.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam int         IW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q, trace_pc_d, trace_addr_q, trace_addr_d, trace_data_q, trace_data_d;
    logic [31:0] mem_q [DEPTH];

    logic [32:0]   off_ext;
    logic [31:0]   off;
    logic          acc_err;
    logic [IW-1:0] idx;
    logic [31:0]   cur_word, merged;
    logic          commit, mem_we;

    // The 33-bit subtraction's borrow flags addresses below BASE.
    always_comb begin
        off_ext  = {1'b0, addr_q} - {1'b0, BASE};
        off      = off_ext[31:0];
        acc_err  = (addr_q[1:0] != 2'b00) || off_ext[32] || ((off >> 2) >= 32'(DEPTH));
        idx      = off[IW+1:2];
        cur_word = acc_err ? 32'h0 : mem_q[idx];
        merged   = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && !acc_err;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        be_d          = be_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    be_d        = req_be;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    pc_d        = req_pc;
                    cnt_d       = CNT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (commit) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = we_q ? 32'h0 : cur_word;
                    if (we_q && !acc_err) begin
                        trace_valid_d = 1'b1;
                        trace_pc_d    = pc_q;
                        trace_addr_d  = {addr_q[31:2], 2'b00};
                        trace_data_d  = merged;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            we_q          <= 1'b0;
            be_q          <= 4'd0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            pc_q          <= 32'h0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'h0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0;
            trace_addr_q  <= 32'h0;
            trace_data_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            be_q          <= be_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    // Reset clears the whole RAM, so an aborted request leaves no trace behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a LATENCY=2 instance and a LATENCY=1 instance, each tracked
// by a transaction-level model and checked every cycle, plus directed literal checks.
module tb_dm_responder;
    localparam int          DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, trace_valid;
    logic [1:0][3:0]  req_be;
    logic [1:0][31:0] req_addr, req_wdata, req_pc, resp_rdata, trace_pc, trace_addr, trace_data;
    logic [1:0][1:0]  dbg_state;

    dm_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_pc(req_pc[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .trace_valid(trace_valid[0]),
        .trace_pc(trace_pc[0]), .trace_addr(trace_addr[0]), .trace_data(trace_data[0]),
        .dbg_state(dbg_state[0]));

    dm_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_pc(req_pc[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .trace_valid(trace_valid[1]),
        .trace_pc(trace_pc[1]), .trace_addr(trace_addr[1]), .trace_data(trace_data[1]),
        .dbg_state(dbg_state[1]));

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Transaction-level model: one outstanding request per instance, response due
    // LATENCY edges after the accept edge, RAM as a plain word array.
    int          lat_of [2] = '{2, 1};
    bit          m_pend [2];
    int          m_wait [2];
    bit          m_fresh[2];
    bit          m_trace[2];
    bit          m_err  [2];
    logic [31:0] m_rdata[2], m_tpc[2], m_taddr[2], m_tdata[2];
    logic [31:0] m_mem  [2][DEPTH];

    function automatic void model_accept(int d);
        logic [32:0] off;
        logic [31:0] w;
        off        = {1'b0, req_addr[d]} - {1'b0, BASE};
        m_err[d]   = (req_addr[d][1:0] != 2'b00) || off[32] || (off[31:2] >= 30'(DEPTH));
        m_rdata[d] = 32'h0;
        m_trace[d] = 1'b0;
        m_pend[d]  = 1'b1;
        m_wait[d]  = lat_of[d];
        if (!m_err[d]) begin
            w = m_mem[d][int'(off[31:2])];
            if (req_we[d]) begin
                for (int b = 0; b < 4; b++) if (req_be[d][b]) w[8*b +: 8] = req_wdata[d][8*b +: 8];
                m_mem[d][int'(off[31:2])] = w;
                m_trace[d] = 1'b1;
                m_tpc[d]   = req_pc[d];
                m_taddr[d] = req_addr[d] & 32'hFFFF_FFFC;
                m_tdata[d] = w;
            end else begin
                m_rdata[d] = w;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_pend[d]  = 1'b0;
                m_fresh[d] = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[d][i] = 32'h0;
            end else begin
                m_fresh[d] = 1'b0;
                if (m_pend[d]) begin
                    if (m_wait[d] == 0) begin
                        if (resp_ready[d]) m_pend[d] = 1'b0;
                    end else begin
                        m_wait[d]--;
                        if (m_wait[d] == 0) m_fresh[d] = 1'b1;
                    end
                end else if (req_valid[d]) begin
                    model_accept(d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                bit ev, et;
                ev = m_pend[d] && (m_wait[d] == 0);
                et = ev && m_fresh[d] && m_trace[d];
                chk($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(!m_pend[d]));
                chk($sformatf("resp_valid[%0d]", d), 32'(resp_valid[d]), 32'(ev));
                chk($sformatf("trace_valid[%0d]", d), 32'(trace_valid[d]), 32'(et));
                if (ev) begin
                    chk($sformatf("resp_rdata[%0d]", d), resp_rdata[d], m_rdata[d]);
                    chk($sformatf("resp_err[%0d]", d), 32'(resp_err[d]), 32'(m_err[d]));
                end
                if (et) begin
                    chk($sformatf("trace_pc[%0d]", d), trace_pc[d], m_tpc[d]);
                    chk($sformatf("trace_addr[%0d]", d), trace_addr[d], m_taddr[d]);
                    chk($sformatf("trace_data[%0d]", d), trace_data[d], m_tdata[d]);
                end
            end
        end
    end

    int          tr_cnt [2] = '{0, 0};
    logic [31:0] last_tpc[2], last_taddr[2], last_tdata[2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (trace_valid[d]) begin
                tr_cnt[d]++;
                last_tpc[d]   = trace_pc[d];
                last_taddr[d] = trace_addr[d];
                last_tdata[d] = trace_data[d];
            end
        end
    end

    // Called just after a rising edge; returns just after the response handshake edge.
    task automatic do_req(input int d, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                          input int hold, output int lat, output logic [31:0] rdata, output logic err);
        bit rdy;
        int n;
        req_valid[d] = 1'b1; req_we[d] = we; req_be[d] = be;
        req_addr[d] = addr; req_wdata[d] = wdata; req_pc[d] = pc;
        resp_ready[d] = (hold == 0);
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = req_ready[d];
            @(posedge clk);
            n++;
        end
        #1;
        req_valid[d] = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout[%0d]: got no accept want accept", d);
        end
        lat = 0;
        while (!resp_valid[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata[d];
        err   = resp_err[d];
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d);
        int n;
        n = 0;
        while (!resp_valid[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("resp_wait_bound", 32'(n < 50), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, tc, n;
        logic [31:0] rd, held;
        logic        er;
        bit          t6_we [6]      = '{1, 0, 1, 0, 1, 0};
        logic [3:0]  t6_be [6]      = '{4'hF, 4'hF, 4'b1100, 4'hF, 4'b0001, 4'hF};
        logic [31:0] t6_addr [6]    = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40};
        logic [31:0] t6_wdata [6]   = '{32'h1122_3344, 0, 32'hAABB_CCDD, 0, 32'h0000_00EE, 0};
        logic [31:0] t6_rd [6]      = '{0, 32'h1122_3344, 0, 32'hAABB_0000, 0, 32'h1122_33EE};

        reset = 1'b1;
        req_valid = '0; req_we = '0; req_be = '0; req_addr = '0; req_wdata = '0; req_pc = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(2'b11));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_trace_valid", 32'(trace_valid), 32'(0));
        chk("rst_resp_rdata", resp_rdata[0], 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'(0));
        chk("rst_trace_data", trace_data[0], 32'h0);
        chk("rst_trace_pc", trace_pc[0], 32'h0);
        reset = 1'b0;

        // Full-word store, then a single-lane merge and a read-back.
        do_req(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h3000, 0, lat, rd, er);
        chk("t1_latency", 32'(lat), 32'(2));
        chk("t1_trace_count", 32'(tr_cnt[0]), 32'(1));
        chk("t1_trace_pc", last_tpc[0], 32'h3000);
        chk("t1_trace_addr", last_taddr[0], 32'h10);
        chk("t1_trace_data", last_tdata[0], 32'hDEAD_BEEF);
        chk("t1_store_rdata", rd, 32'h0);
        do_req(0, 1, 4'b0010, 32'h10, 32'h0000_AA00, 32'h3004, 0, lat, rd, er);
        chk("t2_trace_data", last_tdata[0], 32'hDEAD_AAEF);
        do_req(0, 0, 4'hF, 32'h10, 32'h0, 32'h3008, 0, lat, rd, er);
        chk("t2_load_rdata", rd, 32'hDEAD_AAEF);
        chk("t2_load_err", 32'(er), 32'(0));

        // Misaligned and out-of-range accesses, plus the last valid word.
        tc = tr_cnt[0];
        do_req(0, 0, 4'hF, 32'h13, 32'h0, 32'h300C, 0, lat, rd, er);
        chk("t3_misaligned_err", 32'(er), 32'(1));
        chk("t3_misaligned_rdata", rd, 32'h0);
        do_req(0, 0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, 32'h3010, 0, lat, rd, er);
        chk("t3_range_err", 32'(er), 32'(1));
        chk("t3_range_rdata", rd, 32'h0);
        chk("t3_range_latency", 32'(lat), 32'(2));
        do_req(0, 1, 4'hF, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 32'h3014, 0, lat, rd, er);
        chk("t3_range_store_err", 32'(er), 32'(1));
        chk("t3_no_trace", 32'(tr_cnt[0]), 32'(tc));
        do_req(0, 1, 4'hF, 32'h2FFC, 32'h1234_5678, 32'h3018, 0, lat, rd, er);
        chk("t3_last_word_err", 32'(er), 32'(0));
        do_req(0, 1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h301C, 0, lat, rd, er);
        chk("t3_be0_trace_count", 32'(tr_cnt[0]), 32'(tc + 2));
        chk("t3_be0_trace_data", last_tdata[0], 32'hDEAD_AAEF);
        do_req(0, 0, 4'hF, 32'h10, 32'h0, 32'h3020, 0, lat, rd, er);
        chk("t3_ram_unchanged", rd, 32'hDEAD_AAEF);

        // Response held for 5 cycles while a second request waits.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_be[0] = 4'hF; req_addr[0] = 32'h10;
        resp_ready[0] = 1'b0;
        n = 0;
        while (req_ready[0] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_addr[0] = 32'h2FFC;
        wait_resp(0);
        held = resp_rdata[0];
        chk("t4_held_rdata", held, 32'hDEAD_AAEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", 32'(resp_valid[0]), 32'(1));
            chk("t4_hold_rdata", resp_rdata[0], held);
            chk("t4_hold_ready", 32'(req_ready[0]), 32'(0));
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b0;
        chk("t4_idle_after_release", 32'(req_ready[0]), 32'(1));
        @(posedge clk);
        #1;
        chk("t4_accept_after_release", 32'(req_ready[0]), 32'(0));
        req_valid[0] = 1'b0;
        wait_resp(0);
        chk("t4_second_rdata", resp_rdata[0], 32'h1234_5678);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b0;

        // Reset while a store is waiting aborts it and clears the RAM.
        tc = tr_cnt[0];
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h55AA_55AA; req_pc[0] = 32'h4000;
        @(posedge clk);
        #1;
        chk("t5_in_wait", 32'(req_ready[0]), 32'(0));
        reset = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        chk("t5_ready_on_reset", 32'(req_ready[0]), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_no_trace", 32'(tr_cnt[0]), 32'(tc));
        do_req(0, 0, 4'hF, 32'h20, 32'h0, 32'h4004, 0, lat, rd, er);
        chk("t5_load_aborted", rd, 32'h0);
        do_req(0, 0, 4'hF, 32'h10, 32'h0, 32'h4008, 0, lat, rd, er);
        chk("t5_ram_cleared", rd, 32'h0);

        // LATENCY=1 instance, back-to-back with the response always taken.
        for (int k = 0; k < 6; k++) begin
            do_req(1, t6_we[k], t6_be[k], t6_addr[k], t6_wdata[k], 32'h5000 + 32'(4 * k), 0, lat, rd, er);
            chk($sformatf("t6_latency[%0d]", k), 32'(lat), 32'(1));
            chk($sformatf("t6_rdata[%0d]", k), rd, t6_rd[k]);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
